// File: rtl/svc_rv_halt_reporter_if.sv
// Byte stream from the halt reporter toward the UART transmitter.
// valid/ready handshake carrying one ASCII byte per transfer.
interface svc_rv_halt_reporter_if;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/svc_rv_halt_reporter.sv
// Counts cycles from reset release until ebreak, then streams "C=<hex>\r\n" over a byte interface.
// Optional run-length timeout (prefix 'T') is enabled by defining SVC_RV_HALT_REPORTER_TIMEOUT_EN.
module svc_rv_halt_reporter #(
  parameter int unsigned CNT_W = 32
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ebreak,
  output logic                      halted,
  output logic [CNT_W-1:0]          cycle_cnt,
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
  output logic                      timeout,
`endif
  output logic                      done,
  svc_rv_halt_reporter_if.master    tx
);

  localparam int unsigned N_HEX   = CNT_W / 4;
  localparam int unsigned N_BYTES = N_HEX + 4;
  localparam int unsigned IDX_W   = $clog2(N_BYTES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
  localparam logic [7:0]      CH_T  = 8'h54;
  // Compare in at least 32 bits so a threshold beyond the counter range never fires.
  localparam int unsigned     CMP_W = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [CMP_W-1:0] TIMEOUT_VAL = CMP_W'(TIMEOUT_CYCLES);
`endif

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             halted_q, halted_d;
  logic             done_q,   done_d;
  logic             valid_q,  valid_d;
  logic [7:0]       data_q,   data_d;
  logic [7:0]       prefix_c;
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
  logic             timeout_q, timeout_d;
  logic             timeout_hit_c;
`endif

  // Byte at position idx of the report line; hex nibbles taken from the latched count.
  function automatic logic [7:0] line_byte(input logic [IDX_W-1:0] idx,
                                           input logic [CNT_W-1:0] cnt,
                                           input logic [7:0]       prefix);
    int unsigned i;
    int unsigned pos;
    logic [3:0]  nib;
    i         = 32'(idx);
    pos       = 0;
    nib       = 4'h0;
    line_byte = CH_LF;
    if (i == 0) begin
      line_byte = prefix;
    end else if (i == 1) begin
      line_byte = CH_EQ;
    end else if (i < N_HEX + 2) begin
      pos       = N_HEX + 1 - i;
      nib       = 4'(cnt >> (4 * pos));
      line_byte = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
    end else if (i == N_HEX + 2) begin
      line_byte = CH_CR;
    end
  endfunction

`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
  assign prefix_c      = timeout_q ? CH_T : CH_C;
  assign timeout_hit_c = (CMP_W'(cnt_q) == TIMEOUT_VAL);
`else
  assign prefix_c      = CH_C;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    halted_d = halted_q;
    done_d   = done_q;
    valid_d  = valid_q;
    data_d   = data_q;
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
    timeout_d = timeout_q;
`endif

    case (state_q)
      ST_RUN: begin
        if (ebreak) begin
          halted_d = 1'b1;
          state_d  = ST_SEND;
          valid_d  = 1'b1;
          data_d   = CH_C;
          idx_d    = '0;
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
        end else if (timeout_hit_c) begin
          timeout_d = 1'b1;
          state_d   = ST_SEND;
          valid_d   = 1'b1;
          data_d    = CH_T;
          idx_d     = '0;
`endif
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SEND: begin
        if (valid_q && tx.m_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = line_byte(idx_q + IDX_W'(1), cnt_q, prefix_c);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      idx_q    <= '0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      halted_q <= halted_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign halted     = halted_q;
  assign cycle_cnt  = cnt_q;
  assign done       = done_q;
  assign tx.m_valid = valid_q;
  assign tx.m_data  = data_q;
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
  assign timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_svc_rv_halt_reporter.sv
// Scoreboard bench for svc_rv_halt_reporter: expected line bytes queued at halt, popped on each transfer.
module tb_svc_rv_halt_reporter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ebreak_a, ebreak_b;
  logic        rdy_a, rdy_b;
  logic        halted_a, done_a, halted_b, done_b;
  logic [31:0] cnt_a;
  logic [7:0]  cnt_b;

  svc_rv_halt_reporter_if ifa ();
  svc_rv_halt_reporter_if ifb ();
  assign ifa.m_ready = rdy_a;
  assign ifb.m_ready = rdy_b;

`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
  logic        tmo_a, tmo_b, tmo_c, ebreak_c, rdy_c, halted_c, done_c;
  logic [31:0] cnt_c;
  svc_rv_halt_reporter_if ifc ();
  assign ifc.m_ready = rdy_c;

  svc_rv_halt_reporter #(.CNT_W(32), .TIMEOUT_CYCLES(50)) dut_c (
    .clk(clk), .rst_n(rst_n), .ebreak(ebreak_c), .halted(halted_c),
    .cycle_cnt(cnt_c), .timeout(tmo_c), .done(done_c), .tx(ifc.master)
  );
`endif

  svc_rv_halt_reporter #(.CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .ebreak(ebreak_a), .halted(halted_a),
    .cycle_cnt(cnt_a),
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
    .timeout(tmo_a),
`endif
    .done(done_a), .tx(ifa.master)
  );

  svc_rv_halt_reporter #(.CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .ebreak(ebreak_b), .halted(halted_b),
    .cycle_cnt(cnt_b),
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
    .timeout(tmo_b),
`endif
    .done(done_b), .tx(ifb.master)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Queue the expected report line: prefix, '=', nd hex digits MSB-first, CR, LF.
  task automatic push_line(input logic [7:0] pfx, input logic [31:0] v, input int nd);
    string digs;
    int    nib;
    digs = "0123456789ABCDEF";
    exp_q.push_back(pfx);
    exp_q.push_back(8'h3D);
    for (int i = nd - 1; i >= 0; i--) begin
      nib = int'((v >> (4 * i)) & 32'hF);
      exp_q.push_back(8'(digs[nib]));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic set_ready(input int sel, input logic r);
    rdy_a = (sel == 0) ? r : 1'b0;
    rdy_b = (sel == 1) ? r : 1'b0;
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
    rdy_c = (sel == 2) ? r : 1'b0;
`endif
  endtask

  // Drains the expected queue from the selected DUT; span = cycles from first to last accepted byte.
  task automatic run_line(input int sel, input bit rnd, input int stop_after, output int span);
    int         accepted, budget, first, cyc;
    logic       v, r, pv, pr;
    logic [7:0] d, pd, e;
    accepted = 0; budget = 0; first = -1; cyc = 0;
    pv = 1'b0; pr = 1'b0; pd = 8'h00; span = 0;
    while (exp_q.size() > 0 && budget < 2000) begin
      @(negedge clk);
      cyc++;
      budget++;
      case (sel)
        0:       begin v = ifa.m_valid; d = ifa.m_data; end
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
        2:       begin v = ifc.m_valid; d = ifc.m_data; end
`endif
        default: begin v = ifb.m_valid; d = ifb.m_data; end
      endcase
      if (pv && !pr) begin
        check_eq("stall_valid", 64'(v), 64'd1);
        check_eq("stall_data", 64'(d), 64'(pd));
      end
      if (stop_after >= 0 && accepted >= stop_after) break;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      set_ready(sel, r);
      if (v && r) begin
        e = exp_q.pop_front();
        check_eq($sformatf("byte%0d", accepted), 64'(d), 64'(e));
        accepted++;
        if (first < 0) first = cyc;
        span = cyc - first + 1;
      end
      pv = v; pr = r; pd = d;
    end
    if (budget >= 2000) check_eq("line_budget", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int span;

  initial begin
    rst_n = 1'b0; ebreak_a = 1'b0; ebreak_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
    ebreak_c = 1'b0; rdy_c = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_halted", 64'(halted_a), 64'd0);
    check_eq("rst_cnt", 64'(cnt_a), 64'd0);
    check_eq("rst_valid", 64'(ifa.m_valid), 64'd0);
    check_eq("rst_data", 64'(ifa.m_data), 64'd0);
    check_eq("rst_done", 64'(done_a), 64'd0);
    check_eq("rst_cnt_b", 64'(cnt_b), 64'd0);

    // Halt after 100 low edges, ready always high.
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk) ebreak_a = 1'b1;
    @(posedge clk); #1;
    check_eq("halt_valid", 64'(ifa.m_valid), 64'd1);
    check_eq("halt_halted", 64'(halted_a), 64'd1);
    check_eq("halt_cnt", 64'(cnt_a), 64'd100);
    check_eq("halt_done", 64'(done_a), 64'd0);
    push_line(8'h43, 32'd100, 8);
    run_line(0, 1'b0, -1, span);
    check_eq("line_span", 64'(span), 64'd12);
    @(posedge clk); #1;
    check_eq("end_done", 64'(done_a), 64'd1);
    check_eq("end_valid", 64'(ifa.m_valid), 64'd0);
    check_eq("end_halted", 64'(halted_a), 64'd1);

    // DONE ignores ebreak and ready.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ebreak_a = 1'($urandom_range(0, 1));
      rdy_a    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_eq("post_valid", 64'(ifa.m_valid), 64'd0);
      check_eq("post_done", 64'(done_a), 64'd1);
      check_eq("post_cnt", 64'(cnt_a), 64'd100);
    end

    // Same halt point with random back-pressure.
    ebreak_a = 1'b0;
    apply_reset();
    check_eq("rst2_done", 64'(done_a), 64'd0);
    repeat (100) @(posedge clk);
    @(negedge clk) ebreak_a = 1'b1;
    push_line(8'h43, 32'd100, 8);
    run_line(0, 1'b1, -1, span);
    check_eq("stall_cnt", 64'(cnt_a), 64'd100);
    @(posedge clk); #1;
    check_eq("stall_done", 64'(done_a), 64'd1);

    // Reset in the middle of a line, then a fresh line.
    ebreak_a = 1'b0;
    apply_reset();
    repeat (20) @(posedge clk);
    @(negedge clk) ebreak_a = 1'b1;
    push_line(8'h43, 32'd20, 8);
    run_line(0, 1'b0, 5, span);
    check_eq("mid_data_live", 64'(ifa.m_data), 64'h30);
    rst_n = 1'b0;
    #1;
    check_eq("mid_halted", 64'(halted_a), 64'd0);
    check_eq("mid_cnt", 64'(cnt_a), 64'd0);
    check_eq("mid_valid", 64'(ifa.m_valid), 64'd0);
    check_eq("mid_data", 64'(ifa.m_data), 64'd0);
    check_eq("mid_done", 64'(done_a), 64'd0);
    exp_q.delete();
    ebreak_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk) ebreak_a = 1'b1;
    push_line(8'h43, 32'd7, 8);
    run_line(0, 1'b1, -1, span);
    check_eq("fresh_cnt", 64'(cnt_a), 64'd7);
    @(posedge clk); #1;
    check_eq("fresh_done", 64'(done_a), 64'd1);

    // ebreak already high at reset release.
    @(negedge clk);
    rst_n = 1'b0;
    ebreak_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("zero_cnt", 64'(cnt_a), 64'd0);
    check_eq("zero_valid", 64'(ifa.m_valid), 64'd1);
    push_line(8'h43, 32'd0, 8);
    run_line(0, 1'b0, -1, span);
    check_eq("zero_span", 64'(span), 64'd12);

    // 8-bit counter saturates.
    ebreak_a = 1'b0;
    ebreak_b = 1'b0;
    apply_reset();
    repeat (300) @(posedge clk);
    @(negedge clk) ebreak_b = 1'b1;
    @(posedge clk); #1;
    check_eq("sat_cnt", 64'(cnt_b), 64'hFF);
    check_eq("sat_halted", 64'(halted_b), 64'd1);
    push_line(8'h43, 32'hFF, 2);
    run_line(1, 1'b1, -1, span);
    @(posedge clk); #1;
    check_eq("sat_done", 64'(done_b), 64'd1);
    check_eq("sat_valid", 64'(ifb.m_valid), 64'd0);

`ifdef SVC_RV_HALT_REPORTER_TIMEOUT_EN
    // Timeout at 50 cycles without ebreak.
    ebreak_c = 1'b0;
    apply_reset();
    push_line(8'h54, 32'd50, 8);
    run_line(2, 1'b0, -1, span);
    check_eq("tmo_flag", 64'(tmo_c), 64'd1);
    check_eq("tmo_halted", 64'(halted_c), 64'd0);
    check_eq("tmo_cnt", 64'(cnt_c), 64'd50);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/svc_rv_halt_reporter.md
Name: svc_rv_halt_reporter

Overview:
- Sits directly downstream of the RV SoC demo tops and consumes their `ebreak` output.
- Counts clock cycles from reset release until the core halts, then latches the count.
- Streams the count as an ASCII line over a valid/ready byte interface, which feeds the team's UART TX.
- Lets board-level demos report run length (e.g. forwarding vs non-forwarding CPI comparison) without a debugger.

Parameters:
- CNT_W, 32: cycle counter width. Must be a multiple of 4 and at least 8.
- TIMEOUT_CYCLES, 1000000: timeout threshold. Used only when SVC_RV_HALT_REPORTER_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- ebreak  input  1  halt indication from the SoC (level)
- halted  output  1  high once the halt has been captured
- cycle_cnt  output  CNT_W  latched or running cycle count
- m_valid  output  1  byte stream valid
- m_data  output  8  ASCII byte
- m_ready  input  1  downstream accepts byte
- done  output  1  full line has been transmitted

Behaviour:
- Reset: all outputs are 0 and the FSM is in RUN.
- States are RUN, SEND and DONE.
- RUN:
  - `cycle_cnt` increments by 1 on each rising edge where `ebreak` is sampled low.
  - The counter saturates at all-ones; no wrap.
  - On the edge where `ebreak` is sampled high: `cycle_cnt` holds, `halted` goes to 1, and the FSM enters SEND.
  - Result: if `ebreak` is first high at edge N after reset release, `cycle_cnt` = N (N edges counted while low), saturated.
- SEND:
  - `m_valid` is asserted on the first cycle in SEND (registered output).
  - Byte sequence: 'C' (0x43), '=' (0x3D), then CNT_W/4 uppercase hex digits MSB-first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), then 0x0D, then 0x0A.
  - Total line length is CNT_W/4+4 bytes (12 for CNT_W=32).
  - A byte index counter advances only on `m_valid && m_ready`.
  - While `m_valid && !m_ready`, `m_data` is held stable.
  - `m_valid` is never dropped before acceptance; no bubbles between bytes while `m_ready` stays high.
  - The transfer of the last byte (0x0A) moves the FSM to DONE, with `m_valid` = 0 on the next cycle.
- DONE:
  - `done` = 1 and `halted` = 1; `cycle_cnt` holds.
  - `ebreak` is ignored.
  - The block stays here until reset.
- `ebreak` during SEND is ignored. `ebreak` held high from reset release gives `cycle_cnt` = 0 and the line "C=00000000\r\n".
- `m_ready` is a don't-care whenever `m_valid` = 0.
- Reset asserted mid-SEND or mid-DONE clears everything immediately (asynchronously). After release the block restarts in RUN from a count of 0, and no partial line is resumed.
- The hex nibble is selected combinationally from the latched `cycle_cnt` by the byte index and then registered into `m_data`.

Optional Feature:
- Macro: SVC_RV_HALT_REPORTER_TIMEOUT_EN.
- Defined:
  - Adds an output port `timeout` (1 bit, reset 0).
  - In RUN, if `cycle_cnt` reaches TIMEOUT_CYCLES while `ebreak` is low, the count freezes at TIMEOUT_CYCLES.
  - `timeout` goes to 1, `halted` stays 0, and the FSM enters SEND.
  - The line prefix is 'T' (0x54) instead of 'C'.
  - `ebreak` and timeout on the same edge: `ebreak` wins ('C' prefix, `timeout` = 0).
- Undefined: no `timeout` port, no comparator, and the block waits in RUN forever.

Test Plan:
- Release reset, hold `ebreak` low for 100 edges then high, `m_ready` = 1:
  - `cycle_cnt` = 100, `halted` = 1.
  - Stream is "C=00000064\r\n" on 12 consecutive cycles.
  - `done` = 1 on the cycle after the 0x0A transfer.
- Same stimulus with `m_ready` toggling 1,0,0,1 pseudo-randomly:
  - Identical 12-byte stream.
  - `m_data` stable and `m_valid` held through every stall.
  - No byte skipped or duplicated.
- CNT_W = 8, `ebreak` raised after 300 edges:
  - `cycle_cnt` saturates at 0xFF.
  - Stream is "C=FF\r\n" (6 bytes).
- Assert `rst_n` low after 5 bytes have been accepted:
  - Outputs are 0 immediately.
  - After release, `ebreak` at 7 edges gives a fresh full line "C=00000007\r\n".
- After `done`:
  - Pulse `ebreak` and toggle `m_ready` for 50 cycles.
  - `m_valid` stays 0, `done` stays 1 and `cycle_cnt` is unchanged.
- With SVC_RV_HALT_REPORTER_TIMEOUT_EN and TIMEOUT_CYCLES = 50, no `ebreak`:
  - `timeout` = 1, `halted` = 0.
  - Stream is "T=00000032\r\n".
